// File: rtl/cs_frame_if.sv
// Handshake bundle between the CS frame sequencer, its sample ROM, the filter core and the result RAM.
interface cs_frame_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_q;
  logic              core_rst;
  logic [7:0]        core_x;
  logic [9:0]        core_y;
  logic              res_wr;
  logic [ADDR_W-1:0] res_addr;
  logic [9:0]        res_data;

  // Sequencer side
  modport master (
    input  start, rom_q, core_y,
    output busy, done, rom_rd, rom_addr, core_rst, core_x, res_wr, res_addr, res_data
  );

  // Environment side (ROM, core, result RAM, host)
  modport slave (
    output start, rom_q, core_y,
    input  busy, done, rom_rd, rom_addr, core_rst, core_x, res_wr, res_addr, res_data
  );
endinterface

// File: rtl/cs_frame_ctrl.sv
// Frame sequencer for the 9-tap CS filter core: clears the core, streams one
// frame of ROM samples into it gap-free, and writes each full-window result.
module cs_frame_ctrl #(
  parameter int unsigned N_SAMPLES = 64,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned WIN       = 9
) (
  input  logic       clk,
  input  logic       reset,
  cs_frame_if.master bus
);

  // One extra bit so a frame of 2**ADDR_W samples does not wrap the counters
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] N_CNT     = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] N_RES     = CNT_W'(N_SAMPLES - WIN + 1);
  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(WIN - 1);

  typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, FIN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  in_cnt;
  logic              rd_pend;

  // ROM data is only meaningful in the cycle after a read; otherwise feed zeros
  assign bus.core_x   = rd_pend ? bus.rom_q : 8'd0;
  assign bus.res_data = bus.core_y;

  // Frame FSM plus the sample/result pipeline; all control outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      in_cnt       <= '0;
      rd_pend      <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rom_rd   <= 1'b0;
      bus.rom_addr <= '0;
      bus.core_rst <= 1'b1;
      bus.res_wr   <= 1'b0;
      bus.res_addr <= '0;
    end else begin
      rd_pend    <= bus.rom_rd;
      bus.res_wr <= 1'b0;

      // A sample on core_x this cycle is shifted in at this edge; once the
      // window holds WIN samples, core_y in the next cycle is a valid result.
      if (rd_pend) begin
        in_cnt <= in_cnt + CNT_W'(1);
        if (in_cnt >= LAST_FILL) begin
          bus.res_wr   <= 1'b1;
          bus.res_addr <= wr_cnt[ADDR_W-1:0];
          wr_cnt       <= wr_cnt + CNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          bus.core_rst <= 1'b1;
          if (bus.start) begin
            state    <= CLR;
            bus.busy <= 1'b1;
          end
        end
        CLR: begin
          // Issue address 0 so it is on the bus in the first FEED cycle
          bus.core_rst <= 1'b1;
          bus.rom_rd   <= 1'b1;
          bus.rom_addr <= '0;
          rd_cnt       <= CNT_W'(1);
          wr_cnt       <= '0;
          in_cnt       <= '0;
          state        <= FEED;
        end
        FEED: begin
          // Release the core exactly when sample 0 reaches core_x
          bus.core_rst <= 1'b0;
          if (rd_cnt == N_CNT) begin
            bus.rom_rd <= 1'b0;
            state      <= DRAIN;
          end else begin
            bus.rom_addr <= rd_cnt[ADDR_W-1:0];
            rd_cnt       <= rd_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          // wr_cnt counts writes already scheduled, so this is the last write cycle
          if (wr_cnt == N_RES) begin
            bus.done <= 1'b1;
            state    <= FIN;
          end
        end
        FIN: begin
          bus.done     <= 1'b0;
          bus.busy     <= 1'b0;
          bus.core_rst <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_frame_ctrl.sv
// Scoreboard bench for cs_frame_ctrl: a 64-sample and a 9-sample instance,
// each with a sample ROM and a stand-in filter core y = (sum + sum) / 8.
module tb_cs_frame_ctrl;

  localparam int unsigned N0 = 64;
  localparam int unsigned N1 = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic       start    [2];
  logic       busy     [2];
  logic       done     [2];
  logic       rom_rd   [2];
  logic       core_rst [2];
  logic       res_wr   [2];
  logic [7:0] rom_addr [2];
  logic [7:0] core_x   [2];
  logic [7:0] res_addr [2];
  logic [9:0] res_data [2];
  logic [7:0] rom      [2][64];

  logic [17:0] q0[$];
  logic [17:0] q1[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned nwr    [2];
  int unsigned ra_exp [2];
  logic        prev_wr[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int unsigned N  = (g == 0) ? N0 : N1;
    localparam int unsigned AW = (g == 0) ? 8 : 4;

    cs_frame_if #(.ADDR_W(AW)) bus ();

    cs_frame_ctrl #(.N_SAMPLES(N), .ADDR_W(AW), .WIN(9)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
    );

    logic [7:0]  win [9];
    logic [12:0] sum;

    // Synchronous sample ROM, one cycle read latency
    always_ff @(posedge clk)
      if (bus.rom_rd) bus.rom_q <= rom[g][6'(bus.rom_addr)];

    // Stand-in core: 9-deep shift window, async-cleared by core_rst
    always_ff @(posedge clk or posedge bus.core_rst) begin
      if (bus.core_rst) begin
        for (int i = 0; i < 9; i++) win[i] <= 8'd0;
      end else begin
        win[0] <= bus.core_x;
        for (int i = 1; i < 9; i++) win[i] <= win[i-1];
      end
    end

    // Window sum feeding the combinational core output
    always_comb begin
      sum = '0;
      for (int i = 0; i < 9; i++) sum = sum + 13'(win[i]);
    end

    assign bus.core_y  = 10'((sum + sum) >> 3);
    assign bus.start   = start[g];
    assign busy[g]     = bus.busy;
    assign done[g]     = bus.done;
    assign rom_rd[g]   = bus.rom_rd;
    assign core_rst[g] = bus.core_rst;
    assign res_wr[g]   = bus.res_wr;
    assign rom_addr[g] = 8'(bus.rom_addr);
    assign core_x[g]   = bus.core_x;
    assign res_addr[g] = 8'(bus.res_addr);
    assign res_data[g] = bus.res_data;
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops expected results on each write and checks idle/ROM behaviour
  always @(negedge clk) begin
    logic [17:0] e;
    for (int g = 0; g < 2; g++) begin
      if (res_wr[g]) begin
        nwr[g]++;
        if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
          n_chk++;
          $display("FAIL unexpected_wr: inst %0d wrote addr %0d data %0d, none expected", g, res_addr[g], res_data[g]);
        end else begin
          e = (g == 0) ? q0.pop_front() : q1.pop_front();
          chk("res_addr", res_addr[g], e[17:10]);
          chk("res_data", res_data[g], e[9:0]);
        end
      end
      if (rom_rd[g]) begin
        chk("rom_addr_seq", rom_addr[g], ra_exp[g]);
        ra_exp[g]++;
      end
      if (done[g]) chk("done_after_last_wr", prev_wr[g], 1);
      if (!busy[g]) begin
        chk("idle_core_x", core_x[g], 0);
        chk("idle_res_wr", res_wr[g], 0);
        chk("idle_core_rst", core_rst[g], 1);
      end
      prev_wr[g] = res_wr[g];
    end
  end

  // Fill ROM with a pattern and queue the hand-computed results
  // pat 0: all 50 -> 112; pat 1: 0..8 repeating -> 9; pat 2: all 200 -> 450
  task automatic load(input int g, input int pat);
    int unsigned n;
    logic [9:0]  v;
    n = (g == 0) ? N0 : N1;
    v = (pat == 0) ? 10'd112 : (pat == 1) ? 10'd9 : 10'd450;
    for (int i = 0; i < 64; i++)
      rom[g][i] = (pat == 0) ? 8'd50 : (pat == 1) ? 8'(i % 9) : 8'd200;
    for (int j = 0; j < int'(n) - 8; j++) begin
      if (g == 0) q0.push_back({8'(j), v});
      else        q1.push_back({8'(j), v});
    end
  endtask

  task automatic frame(input int g, input int pat, input bit pulse, input bit hold, input int rst_at);
    int unsigned n_s, w0, m, n;
    int first;
    n_s = (g == 0) ? N0 : N1;
    load(g, pat);
    ra_exp[g] = 0;
    w0 = nwr[g];
    if (!start[g]) begin
      @(posedge clk); #1;
      start[g] = 1'b1;
    end
    m = 0;
    while (!busy[g] && m < 20) begin
      @(posedge clk); #1;
      m++;
    end
    chk("start_to_clr", m, 1);
    if (!hold) start[g] = 1'b0;
    chk("clr_rom_rd", rom_rd[g], 0);
    chk("clr_core_x", core_x[g], 0);
    chk("clr_res_wr", res_wr[g], 0);
    chk("clr_core_rst", core_rst[g], 1);
    @(posedge clk); #1;
    chk("feed_rom_rd", rom_rd[g], 1);
    chk("feed_addr0", rom_addr[g], 0);
    chk("feed_core_rst_held", core_rst[g], 1);
    n = 0;
    first = -1;
    while (n < 300) begin
      if (pulse) start[g] = (n == 5 || n == n_s);
      if (n == 1) chk("core_rst_release", core_rst[g], 0);
      if (res_wr[g] && first < 0) first = int'(n);
      if (rst_at >= 0 && res_wr[g] && res_addr[g] == 8'(rst_at)) begin
        reset = 1'b1;
        #1;
        chk("rst_res_wr", res_wr[g], 0);
        chk("rst_busy", busy[g], 0);
        chk("rst_core_rst", core_rst[g], 1);
        chk("rst_rom_rd", rom_rd[g], 0);
        if (g == 0) q0.delete(); else q1.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_done", done[g], 0);
        reset = 1'b0;
        return;
      end
      if (done[g]) break;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      n_chk++;
      $display("FAIL done_timeout: inst %0d no done within %0d cycles", g, n);
      return;
    end
    chk("first_wr_latency", first, 10);
    chk("done_latency", n, n_s + 2);
    chk("wr_count", nwr[g] - w0, n_s - 8);
    @(posedge clk); #1;
    chk("done_one_cycle", done[g], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    nwr[0] = 0; nwr[1] = 0;
    ra_exp[0] = 0; ra_exp[1] = 0;
    prev_wr[0] = 1'b0; prev_wr[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy0", busy[0], 0);
    chk("rst_done0", done[0], 0);
    chk("rst_rom_rd0", rom_rd[0], 0);
    chk("rst_rom_addr0", rom_addr[0], 0);
    chk("rst_core_rst0", core_rst[0], 1);
    chk("rst_core_x0", core_x[0], 0);
    chk("rst_res_wr0", res_wr[0], 0);
    chk("rst_res_addr0", res_addr[0], 0);
    reset = 1'b0;

    frame(0, 0, 1'b0, 1'b0, -1);   // all 50, 56 writes of 112
    frame(1, 1, 1'b0, 1'b0, -1);   // N=9, single write of 9
    frame(0, 2, 1'b0, 1'b1, -1);   // all 200, start held into next frame
    frame(0, 1, 1'b0, 1'b0, -1);   // back-to-back 0..8 repeating, all 9
    frame(0, 0, 1'b1, 1'b0, -1);   // start pulses in FEED and DRAIN ignored
    frame(0, 0, 1'b0, 1'b0, 10);   // reset at write 10
    frame(0, 0, 1'b0, 1'b0, -1);   // full frame after the abort

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
